// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode sources, stage writers and halt request in,
// forwarding selects, pipeline holds, squash, state and event counters out.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       Rs_D;
   logic [4:0]       Rt_D;
   logic             UseRs_D;
   logic             UseRt_D;
   logic             take_D;
   logic             RegWr_EX;
   logic             MemRd_EX;
   logic [4:0]       Rd_EX;
   logic             RegWr_MEM;
   logic [4:0]       Rd_MEM;
   logic             RegWr_WB;
   logic [4:0]       Rd_WB;
   logic             halt_req;
   logic [1:0]       fwdA;
   logic [1:0]       fwdB;
   logic             stall;
   logic             disable_IR;
   logic             disable_PC;
   logic             kill;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] kill_cnt;

   modport master (
      output Rs_D, Rt_D, UseRs_D, UseRt_D, take_D, RegWr_EX, MemRd_EX, Rd_EX,
             RegWr_MEM, Rd_MEM, RegWr_WB, Rd_WB, halt_req,
      input  fwdA, fwdB, stall, disable_IR, disable_PC, kill, state, stall_cnt, kill_cnt
   );

   modport slave (
      input  Rs_D, Rt_D, UseRs_D, UseRt_D, take_D, RegWr_EX, MemRd_EX, Rd_EX,
             RegWr_MEM, Rd_MEM, RegWr_WB, Rd_WB, halt_req,
      output fwdA, fwdB, stall, disable_IR, disable_PC, kill, state, stall_cnt, kill_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubble, multi-slot branch
// squash, external halt sequencing and saturating stall/kill event counters.
module hazard_ctrl #(
   parameter int unsigned KILL_SLOTS = 1,
   parameter int unsigned CNT_W      = 16
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StKill = 2'd1,
      StHalt = 2'd2
   } state_e;

   localparam logic [2:0] KReload = 3'(KILL_SLOTS - 1);

   state_e           r_state, w_state_d;
   logic [2:0]       r_kcnt, w_kcnt_d;
   logic [CNT_W-1:0] r_stall_cnt, r_kill_cnt;

   logic w_ex_a, w_mem_a, w_wb_a, w_ex_b, w_mem_b, w_wb_b;
   logic w_lu, w_halt, w_br, w_hold, w_kill;

   // Register 0 never matches, so all-zero NOPs create no hazards.
   function automatic logic match(input logic use_src, input logic [4:0] src,
                                  input logic wr, input logic [4:0] dst);
      return use_src & wr & (src == dst) & (src != 5'd0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic ex, input logic ex_load,
                                          input logic mem, input logic wb);
      if (ex && !ex_load) return 2'd1;
      if (mem)            return 2'd2;
      if (wb)             return 2'd3;
      return 2'd0;
   endfunction

   assign w_ex_a  = match(bus.UseRs_D, bus.Rs_D, bus.RegWr_EX, bus.Rd_EX);
   assign w_mem_a = match(bus.UseRs_D, bus.Rs_D, bus.RegWr_MEM, bus.Rd_MEM);
   assign w_wb_a  = match(bus.UseRs_D, bus.Rs_D, bus.RegWr_WB, bus.Rd_WB);
   assign w_ex_b  = match(bus.UseRt_D, bus.Rt_D, bus.RegWr_EX, bus.Rd_EX);
   assign w_mem_b = match(bus.UseRt_D, bus.Rt_D, bus.RegWr_MEM, bus.Rd_MEM);
   assign w_wb_b  = match(bus.UseRt_D, bus.Rt_D, bus.RegWr_WB, bus.Rd_WB);

   assign w_lu   = (w_ex_a | w_ex_b) & bus.MemRd_EX;
   assign w_halt = (r_state == StHalt);
   assign w_hold = w_lu | w_halt;
   // A stalled decode slot is not a valid instruction, so its take_D is ignored.
   assign w_br   = bus.take_D & ~w_lu & ~w_halt;
   assign w_kill = w_br | (r_state == StKill);

   assign bus.fwdA       = fwd_sel(w_ex_a, bus.MemRd_EX, w_mem_a, w_wb_a);
   assign bus.fwdB       = fwd_sel(w_ex_b, bus.MemRd_EX, w_mem_b, w_wb_b);
   assign bus.stall      = w_hold;
   assign bus.disable_IR = w_hold;
   assign bus.disable_PC = w_hold;
   assign bus.kill       = w_kill;
   assign bus.state      = r_state;
   assign bus.stall_cnt  = r_stall_cnt;
   assign bus.kill_cnt   = r_kill_cnt;

   always_comb begin
      w_state_d = r_state;
      w_kcnt_d  = r_kcnt;
      unique case (r_state)
         StRun: begin
            if (w_br && (KILL_SLOTS > 1)) begin
               w_state_d = StKill;
               w_kcnt_d  = KReload;
            end else if (bus.halt_req && !w_br) begin
               w_state_d = StHalt;
            end
         end
         StKill: begin
            if (w_br) begin
               w_kcnt_d = KReload;
            end else begin
               w_kcnt_d = r_kcnt - 3'd1;
               if (r_kcnt == 3'd1) w_state_d = StRun;
            end
         end
         StHalt: begin
            if (!bus.halt_req) w_state_d = StRun;
         end
         default: w_state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StRun;
         r_kcnt      <= 3'd0;
         r_stall_cnt <= '0;
         r_kill_cnt  <= '0;
      end else begin
         r_state <= w_state_d;
         r_kcnt  <= w_kcnt_d;
         if (w_hold && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_kill && (r_kill_cnt != '1))  r_kill_cnt  <= r_kill_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It watches destination registers and control bits in the EX, MEM and WB stages against decode-stage sources. From these it generates:
- operand-forwarding selects for the decode operand muxes;
- the load-use bubble (`stall`) into the ID/EX register;
- fetch hold signals (`disable_PC`, `disable_IR`);
- the wrong-path squash (`kill`) into the IF/ID register.

It also sequences multi-slot branch squash and external halt, and keeps saturating stall and kill event counters.

## Interface
Parameters:
- `KILL_SLOTS`, default 1: fetched instructions squashed per taken branch/jump (1..7).
- `CNT_W`, default 16: width of each event counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `Rs_D`, `Rt_D` in 5: decode source register numbers.
- `UseRs_D`, `UseRt_D` in 1: decode instruction actually reads Rs/Rt.
- `take_D` in 1: branch/jump in decode resolved taken.
- `RegWr_EX`, `MemRd_EX` in 1; `Rd_EX` in 5: EX-stage writer.
- `RegWr_MEM` in 1; `Rd_MEM` in 5: MEM-stage writer.
- `RegWr_WB` in 1; `Rd_WB` in 5: WB-stage writer.
- `halt_req` in 1: external freeze of fetch/issue (debug).
- `fwdA`, `fwdB` out 2: 0 = regfile, 1 = EX result, 2 = MEM write-back value, 3 = WB write-back value.
- `stall` out 1: bubble into ID/EX.
- `disable_IR` out 1: hold IF/ID.
- `disable_PC` out 1: hold PC.
- `kill` out 1: IF/ID loads NOP.
- `state` out 2: 0 RUN, 1 KILL, 2 HALT.
- `stall_cnt`, `kill_cnt` out CNT_W: event counters.

## Operation
- Match rule: a source matches a stage when its Use bit is 1, the stage's `RegWr` is 1, the register numbers are equal, and the register is not 0. Register 0 never matches, so NOP (all-zero) never creates a hazard.
- Forwarding (combinational, per operand): priority EX > MEM > WB > regfile, taking the most recent writer.
  - EX match with `MemRd_EX`=1 does not forward; it raises load-use instead.
  - In that case the operand select falls through to MEM/WB/regfile. The value is don't-care because the cycle is stalled.
- Load-use (combinational): `lu` = EX match on either operand with `MemRd_EX`=1.
- Output equations:
  - `stall` = `lu` | (state == HALT).
  - `disable_IR` = `disable_PC` = `lu` | (state == HALT).
- Branch squash: `br` = `take_D` & !`lu` & (state != HALT). While stalled, the decode instruction is not valid to resolve, so `take_D` is ignored.
- `kill` = `br` | (state == KILL). `kill` never asserts together with `disable_IR`.
- FSM, registered, with `kcnt` a 3-bit down-counter:
  - RUN:
    - If `br` and KILL_SLOTS > 1: go to KILL, `kcnt` = KILL_SLOTS-1.
    - Else if `halt_req` and !`br`: go to HALT.
    - Else stay in RUN.
  - KILL:
    - Each cycle, `kcnt`--.
    - When `kcnt` == 1 at the edge: go to RUN.
    - `halt_req` is ignored until RUN is reached.
    - A new `take_D` in KILL is a squashed NOP, so it cannot occur. If it does, it reloads `kcnt` = KILL_SLOTS-1.
  - HALT: go to RUN when `halt_req` = 0.
- Counters:
  - `stall_cnt` increments on every cycle with `stall`=1.
  - `kill_cnt` increments on every cycle with `kill`=1.
  - Both saturate at all-ones and never wrap.
- Reset, asynchronous, also mid-sequence: state = RUN, `kcnt` = 0, both counters = 0. Combinational outputs then follow inputs: with idle inputs, `fwdA` = `fwdB` = 0 and `stall` = `kill` = `disable_IR` = `disable_PC` = 0.

## Timing
- Forwarding, `lu`, `stall`, `disable_*` and the first `kill` are same-cycle combinational. They are sampled by the pipeline registers at the next rising edge.
- Load-use costs exactly one bubble. In the next cycle the load is in MEM, `lu` = 0 and `fwd` = 2.
- Taken branch in cycle t: `kill` is high in cycles t..t+KILL_SLOTS-1, giving KILL_SLOTS NOPs in IF/ID.
- HALT entry takes effect from the cycle after `halt_req` is sampled in RUN. Exit: `stall` is 0 in the cycle after `halt_req` is seen low.
- State and counters update only on the rising edge of `clk`, or asynchronously on reset.

## Test plan
- Forward priority: `Rs_D`=5, `UseRs_D`=1, EX/MEM/WB all writing r5 with `MemRd_EX`=0 -> `fwdA`=1. Drop `RegWr_EX` -> `fwdA`=2. Drop `RegWr_MEM` -> `fwdA`=3. Set `Rs_D`=0 -> `fwdA`=0.
- Load-use: `MemRd_EX`=`RegWr_EX`=1, `Rd_EX`=7, `Rt_D`=7, `UseRt_D`=1 -> `stall`=`disable_IR`=`disable_PC`=1 for one cycle, `stall_cnt` 0→1. Next cycle, with the load moved to MEM -> `fwdB`=2, `stall`=0. With `UseRt_D`=0 -> no stall.
- Branch squash with KILL_SLOTS=3: `take_D`=1 for one cycle -> `kill` high for exactly 3 cycles, `state` 0→1→1→0, `kill_cnt`=3.
- Stall vs branch: `take_D`=1 coincident with load-use -> `kill`=0, `stall`=1. Branch resolved next cycle -> `kill`=1.
- Halt: `halt_req` high for 4 cycles in RUN -> `state`=2 for 4 cycles, `stall`=`disable_PC`=1, `kill`=0. Assert `halt_req` during KILL -> HALT is entered only after KILL completes.
- Reset mid-KILL and counter saturation: assert `reset` during KILL -> state 0, counters 0, `kill`=0 immediately. Set CNT_W=2 and hold load-use for 5 cycles -> `stall_cnt` stays at 3.
